// File: rtl/program_loader_pkg.sv
// loader_pkg: shared sizing constants, instruction-word layout and FSM state codes for program_loader.
package loader_pkg;
  localparam int ADDRESS_SIZE = 11;
  localparam int WORD_SIZE = 64;
  localparam int INSTRUCTION_SIZE = 20;
  localparam int ADDRESS_STRIDE = 4;
  localparam int MAX_INSTRUCTIONS = 512;
  localparam int INSTR_LSB = 32;
  localparam int PAD_WIDTH = 12;
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LEN_HI = 4'd1;
  localparam logic [3:0] S_LEN_LO = 4'd2;
  localparam logic [3:0] S_B0     = 4'd3;
  localparam logic [3:0] S_B1     = 4'd4;
  localparam logic [3:0] S_B2     = 4'd5;
  localparam logic [3:0] S_WRITE  = 4'd6;
  localparam logic [3:0] S_FINISH = 4'd7;
  localparam logic [3:0] S_CHECK  = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;
  localparam logic [3:0] S_ERROR  = 4'd10;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream handshake plus RAM write port and load status of program_loader.
interface program_loader_if;
  import loader_pkg::*;
  logic in_valid;
  logic [7:0] in_data;
  logic in_ready;
  logic [ADDRESS_SIZE-1:0] mem_address;
  logic [WORD_SIZE-1:0] mem_data;
  logic mem_write;
  logic busy;
  logic done;
  logic error;
  logic cpu_run;
  modport master(output in_valid, in_data, input in_ready, mem_address, mem_data, mem_write, busy, done, error, cpu_run);
  modport slave(input in_valid, in_data, output in_ready, mem_address, mem_data, mem_write, busy, done, error, cpu_run);
endinterface

// File: rtl/program_loader_assembler.sv
// instruction_assembler: big-endian byte shifter yielding the low 20 of each 24-bit group;
// LOADER_CHECKSUM_EN adds a running XOR of every loaded byte.
module instruction_assembler
  import loader_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic [7:0] i_byte,
`ifdef LOADER_CHECKSUM_EN
  output logic [7:0] o_xor,
`endif
  output logic [INSTRUCTION_SIZE-1:0] o_instr
);
  // Only 20 bits are kept: the first byte's top nibble shifts out on the third load.
  logic [INSTRUCTION_SIZE-1:0] r_shift;
  always_ff @(posedge clk) begin
    if (!rst_n) r_shift <= '0;
    else if (i_load) r_shift <= {r_shift[INSTRUCTION_SIZE-9:0], i_byte};
  end
  assign o_instr = r_shift;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_xor;
  always_ff @(posedge clk) begin
    if (!rst_n) r_xor <= '0;
    else if (i_load) r_xor <= r_xor ^ i_byte;
  end
  assign o_xor = r_xor;
`endif
endmodule

// File: rtl/program_loader.sv
// program_loader: boot loader assembling 20-bit instructions from a byte stream into CPU RAM, then releasing the CPU.
// LOADER_CHECKSUM_EN appends a trailing XOR checksum byte that must match before DONE.
module program_loader
  import loader_pkg::*;
(
  input logic clk,
  input logic rst_n,
  program_loader_if.slave bus
);
  logic [3:0] r_state, w_next;
  logic [15:0] r_count;
  logic [ADDRESS_SIZE-1:0] r_index;
  logic [15:0] w_n;
  logic [INSTRUCTION_SIZE-1:0] w_instr;
  logic w_accept, w_more, w_write, w_load;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] w_xor;
  assign bus.in_ready = r_state inside {S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2, S_CHECK};
`else
  assign bus.in_ready = r_state inside {S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2};
`endif
  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_n = {r_count[15:8], bus.in_data};
  assign w_more = (16'(r_index) + 16'd1) < r_count;
  assign w_write = r_state == S_WRITE;
  assign w_load = w_accept && (r_state inside {S_B0, S_B1, S_B2});
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_LEN_HI;
      S_LEN_HI: w_next = w_accept ? S_LEN_LO : r_state;
      S_LEN_LO: w_next = !w_accept ? r_state : w_n == '0 ? S_FINISH : w_n > 16'(MAX_INSTRUCTIONS) ? S_ERROR : S_B0;
      S_B0:     w_next = w_accept ? S_B1 : r_state;
      S_B1:     w_next = w_accept ? S_B2 : r_state;
      S_B2:     w_next = w_accept ? S_WRITE : r_state;
      S_WRITE:  w_next = w_more ? S_B0 : S_FINISH;
`ifdef LOADER_CHECKSUM_EN
      S_FINISH: w_next = S_CHECK;
      S_CHECK:  w_next = !w_accept ? r_state : bus.in_data == w_xor ? S_DONE : S_ERROR;
`else
      S_FINISH: w_next = S_DONE;
`endif
      default:  w_next = r_state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_index <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept && r_state == S_LEN_HI) r_count[15:8] <= bus.in_data;
      if (w_accept && r_state == S_LEN_LO) r_count[7:0] <= bus.in_data;
      if (w_write) r_index <= r_index + ADDRESS_SIZE'(1);
    end
  end
  instruction_assembler u_asm (
    .clk(clk),
    .rst_n(rst_n),
    .i_load(w_load),
    .i_byte(bus.in_data),
`ifdef LOADER_CHECKSUM_EN
    .o_xor(w_xor),
`endif
    .o_instr(w_instr)
  );
  assign bus.mem_write = w_write;
  assign bus.mem_address = ADDRESS_SIZE'(r_index * ADDRESS_STRIDE);
  assign bus.mem_data = w_write ? {PAD_WIDTH'(0), w_instr, INSTR_LSB'(0)} : '0;
  assign bus.busy = !(r_state inside {S_IDLE, S_DONE, S_ERROR});
  assign bus.done = r_state == S_DONE;
  assign bus.error = r_state == S_ERROR;
  assign bus.cpu_run = r_state == S_DONE;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven and randomized stream tests of program_loader against a stream-level model.
module tb_program_loader;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    string name;
    int len;
    logic [95:0] b;
    int vmode;
    int nwr;
    bit d;
    bit e;
    int acc;
  } vec_t;
  logic clk = 0;
  logic rst_n = 0;
  program_loader_if b ();
  program_loader dut (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  int tests = 0, fails = 0, acc = 0;
  logic [10:0] got_addr[$], exp_addr[$];
  logic [63:0] got_data[$], exp_data[$];
  bit got_done, got_err, exp_done, exp_err;
  vec_t vt[6];
  int nv;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic logic [80:0] outs();
    return {b.in_ready, b.mem_address, b.mem_data, b.mem_write, b.busy, b.done, b.error, b.cpu_run};
  endfunction
  function automatic bq_t with_cs(input bq_t q);
    bq_t r = q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] cs = 0;
    for (int i = 2; i < q.size(); i++) cs ^= q[i];
    r.push_back(cs);
`endif
    return r;
  endfunction
  // Reference: what a correct loader writes and how it ends, straight from the stream format.
  task automatic model(input bq_t s);
    int n;
    logic [7:0] cs;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 0;
    exp_err = 0;
    cs = 0;
    n = {s[0], s[1]};
    if (n > 512) begin
      exp_err = 1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(11'(4 * i));
      exp_data.push_back(64'({s[2+3*i][3:0], s[3+3*i], s[4+3*i]}) << 32);
      cs = cs ^ s[2+3*i] ^ s[3+3*i] ^ s[4+3*i];
    end
`ifdef LOADER_CHECKSUM_EN
    if (s[2+3*n] == cs) exp_done = 1;
    else exp_err = 1;
`else
    exp_done = 1;
`endif
  endtask
  task automatic run(input string name, input bq_t s, input int vmode, input int abort_at);
    int cyc, last_acc, last_w, k;
    bit fin, v, a;
    model(s);
    got_addr.delete();
    got_data.delete();
    acc = 0; k = 0; cyc = 0; last_acc = -10; last_w = -10; fin = 0;
    @(negedge clk);
    rst_n = 0;
    b.in_valid = 0;
    b.in_data = 0;
    @(negedge clk);
    chk({name, ":rst"}, 128'(outs()), 0);
    rst_n = 1;
    @(negedge clk);
    cyc = 1;
    chk({name, ":ready"}, {b.in_ready, b.busy}, 2'b11);
    while (!fin && cyc < 3000) begin
      if (b.mem_write) begin
        if (vmode == 0 && got_addr.size() > 0) chk({name, ":spacing"}, cyc - last_w, 4);
        chk({name, ":wlat"}, cyc, last_acc);
        last_w = cyc;
        got_addr.push_back(b.mem_address);
        got_data.push_back(b.mem_data);
      end
      if (b.done || b.error) fin = 1;
      else begin
        v = vmode == 0 ? 1'b1 : vmode == 1 ? cyc[0] : ($urandom_range(0, 3) != 0);
        b.in_valid = (k < s.size()) && v;
        b.in_data = (k < s.size() && v) ? s[k] : 8'($urandom);
        a = b.in_valid && b.in_ready;
        @(posedge clk);
        cyc++;
        if (a) begin
          k++;
          acc++;
          last_acc = cyc;
        end
        if (abort_at > 0 && acc == abort_at) begin
          @(negedge clk);
          rst_n = 0;
          b.in_valid = 0;
          @(negedge clk);
          chk({name, ":abort"}, 128'(outs()), 0);
          rst_n = 1;
          return;
        end
        @(negedge clk);
      end
    end
    b.in_valid = 0;
    if (!fin) chk({name, ":timeout"}, 0, 1);
    got_done = b.done;
    got_err = b.error;
    chk({name, ":status"}, {b.done, b.error, b.cpu_run, b.busy}, {exp_done, exp_err, exp_done, 1'b0});
    chk({name, ":nwr"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      chk($sformatf("%s:addr%0d", name, i), got_addr[i], exp_addr[i]);
      chk($sformatf("%s:data%0d", name, i), got_data[i], exp_data[i]);
    end
`ifndef LOADER_CHECKSUM_EN
    if (got_done && got_addr.size() > 0) chk({name, ":donelat"}, cyc - last_w, 2);
    if (got_done && got_addr.size() == 0) chk({name, ":donelat0"}, (cyc - last_acc) <= 2, 1);
`endif
    b.in_valid = 1;
    b.in_data = 8'h5A;
    repeat (3) @(negedge clk);
    chk({name, ":term"}, {b.in_ready, b.done, b.error}, {1'b0, exp_done, exp_err});
    b.in_valid = 0;
  endtask
  initial begin
    bq_t s;
    int n;
    b.in_valid = 0;
    b.in_data = 0;
`ifdef LOADER_CHECKSUM_EN
    nv = 6;
    vt[0] = '{"n2", 9, 96'h0002_0ABCDE_F12345_FF_0000_00, 0, 2, 1, 0, 9};
    vt[1] = '{"n0", 3, 96'h0, 0, 0, 1, 0, 3};
    vt[2] = '{"n513", 2, 96'h0201_0000_0000_0000_0000_0000, 0, 0, 0, 1, 2};
    vt[3] = '{"toggle", 6, 96'h0001_0ABCDE_68_0000_0000_0000, 1, 1, 1, 0, 6};
    vt[4] = '{"cs_ok", 6, 96'h0001_010203_00_0000_0000_0000, 0, 1, 1, 0, 6};
    vt[5] = '{"cs_bad", 6, 96'h0001_010203_01_0000_0000_0000, 0, 1, 0, 1, 6};
`else
    nv = 4;
    vt[0] = '{"n2", 8, 96'h0002_0ABCDE_F12345_0000_0000, 0, 2, 1, 0, 8};
    vt[1] = '{"n0", 2, 96'h0, 0, 0, 1, 0, 2};
    vt[2] = '{"n513", 2, 96'h0201_0000_0000_0000_0000_0000, 0, 0, 0, 1, 2};
    vt[3] = '{"toggle", 5, 96'h0001_0ABCDE_0000_0000_0000_00, 1, 1, 1, 0, 5};
`endif
    for (int i = 0; i < nv; i++) begin
      s.delete();
      for (int j = 0; j < vt[i].len; j++) s.push_back(vt[i].b[95-8*j -: 8]);
      run(vt[i].name, s, vt[i].vmode, 0);
      chk({vt[i].name, ":acc"}, acc, vt[i].acc);
      chk({vt[i].name, ":tnwr"}, got_addr.size(), vt[i].nwr);
      chk({vt[i].name, ":tend"}, {got_done, got_err}, {vt[i].d, vt[i].e});
      if (i == 0 && got_data.size() == 2) begin
        chk("n2:w0", {got_addr[0], got_data[0]}, {11'd0, 12'd0, 20'hABCDE, 32'd0});
        chk("n2:w1", {got_addr[1], got_data[1]}, {11'd4, 12'd0, 20'h12345, 32'd0});
      end
    end
    s = with_cs('{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99});
    run("pass2_abort", s, 0, 6);
    s = with_cs('{8'h00, 8'h01, 8'hFE, 8'hDC, 8'hBA});
    run("pass2_reload", s, 0, 0);
    chk("pass2:addr0", {got_addr.size() == 1, got_done}, 2'b11);
    for (int t = 0; t < 12; t++) begin
      s.delete();
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(513, 2000)) : int'($urandom_range(0, 6));
      s.push_back(8'(n >> 8));
      s.push_back(8'(n));
      if (n <= 512) begin
        for (int i = 0; i < 3 * n; i++) s.push_back(8'($urandom));
        s = with_cs(s);
`ifdef LOADER_CHECKSUM_EN
        if ($urandom_range(0, 3) == 0) s[s.size()-1] ^= 8'($urandom_range(1, 255));
`endif
      end
      run($sformatf("rnd%0d", t), s, 2, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader that sits directly upstream of the multicycle CPU's RAM. It receives a byte stream over a valid/ready handshake and assembles 20-bit instructions. It writes each instruction into RAM in the CPU's instruction word layout, then releases the CPU. While loading, it owns the RAM write port and holds the CPU stalled through `cpu_run`.

## Interface
- `ADDRESS_SIZE`, 11, RAM address width
- `WORD_SIZE`, 64, RAM data width
- `INSTRUCTION_SIZE`, 20, instruction width
- `ADDRESS_STRIDE`, 4, address increment per instruction (matches PC+4)
- `MAX_INSTRUCTIONS`, 512, capacity limit (2^ADDRESS_SIZE / ADDRESS_STRIDE)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  byte available on `in_data`
- `in_data`  in  8  stream byte
- `in_ready`  out  1  loader can accept a byte this cycle
- `mem_address`  out  ADDRESS_SIZE  RAM write address
- `mem_data`  out  WORD_SIZE  RAM write data
- `mem_write`  out  1  one-cycle RAM write strobe
- `busy`  out  1  load in progress
- `done`  out  1  load completed successfully (sticky)
- `error`  out  1  load aborted (sticky)
- `cpu_run`  out  1  CPU clock-enable/release; high only when `done`

## Operation
- Byte transfer occurs on a rising edge with `in_valid && in_ready`. `in_data` is ignored otherwise.
- Stream format:
  - 2-byte instruction count N, big-endian, 16 bits.
  - Then N × 3 bytes per instruction, big-endian.
  - The upper 4 bits of the first instruction byte are discarded; the instruction is the low 20 of 24 bits.
- States:
  - IDLE → LEN_HI: on the first cycle after reset.
  - LEN_HI → LEN_LO: on accept.
  - LEN_LO → B0: on accept, if 0 < N ≤ MAX_INSTRUCTIONS.
  - LEN_LO → FINISH: if N == 0.
  - LEN_LO → ERROR: if N > MAX_INSTRUCTIONS.
  - B0 → B1 → B2: one byte accepted per state.
  - B2 → WRITE: on accept.
  - WRITE → B0: if fewer than N instructions have been written.
  - WRITE → FINISH: otherwise.
  - FINISH → DONE: in one cycle.
  - DONE and ERROR are terminal until reset.
- WRITE drives the following for exactly one cycle:
  - `mem_write` = 1
  - `mem_address` = index × ADDRESS_STRIDE, where index starts at 0
  - `mem_data` = {12'b0, instr[19:0], 32'b0}; the instruction occupies bits [51:32], and all other bits are zero.
- Index width is ADDRESS_SIZE. MAX_INSTRUCTIONS guarantees the address never wraps.
- `in_ready` = 1 in LEN_HI, LEN_LO, B0, B1 and B2, and 0 in every other state.
- `busy` = 1 in every state except IDLE, DONE and ERROR.
- `done` = 1 in DONE. `error` = 1 in ERROR. `cpu_run` = `done`.

## Timing
- Reset values:
  - State = IDLE, index = 0, N = 0.
  - All outputs 0, including `in_ready` = 0, `mem_write` = 0, `mem_address` = 0 and `mem_data` = 0.
- `in_ready` rises one cycle after `rst_n` deasserts.
- Per-instruction cost: 3 accepted bytes plus 1 WRITE cycle. Minimum 4 cycles per instruction with `in_valid` held high.
- `mem_write` asserts in the cycle after the third byte is accepted.
- `done` and `cpu_run` rise 2 cycles after the last WRITE cycle (WRITE→FINISH→DONE).
- `in_valid` low stalls the current state indefinitely. No timeout.
- Reset mid-load returns to IDLE with all outputs 0 on the next edge. RAM contents already written are not cleared.
- Bytes offered in DONE or ERROR are never accepted (`in_ready` = 0).

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - After the last instruction, FINISH becomes CHECK, which accepts one extra byte with `in_ready` = 1.
  - The expected value is the XOR of all 3N instruction bytes; the length bytes are excluded.
  - Match → DONE. Mismatch → ERROR, so `cpu_run` stays 0.
  - N == 0 still requires a checksum byte equal to 8'h00.
- `LOADER_CHECKSUM_EN` undefined: no checksum byte; FINISH → DONE directly.

## Structure
- Shared package `loader_pkg` contains:
  - the state enumeration (IDLE, LEN_HI, LEN_LO, B0, B1, B2, WRITE, FINISH, CHECK, DONE, ERROR)
  - the instruction-word bit-position constants (instruction LSB 32, pad width 12)
- One sub-module, `instruction_assembler`:
  - Function: 24-bit byte shift register with load-enable, big-endian.
  - Output: the 20-bit instruction.
  - Checksum: running XOR accumulator, compiled in under the macro.

## Test plan
- N = 2, bytes 00 02 | 0A BC DE | F1 23 45 →
  - writes at address 0 with data[51:32] = 20'hABCDE and address 4 with data[51:32] = 20'h12345
  - all other data bits 0
  - `done` = `cpu_run` = 1 two cycles after the second write
- N = 0 (00 00) → no `mem_write`; `done` within 2 cycles (with checksum: after byte 00).
- N = 513 (02 01) → `error` = 1, `in_ready` = 0, `cpu_run` = 0, no writes.
- Pass 1: N = 1 with `in_valid` toggled every other cycle → same single write; byte count accepted exactly 5.
- Pass 2: N = 3 with `rst_n` pulsed low after the 4th instruction byte → all outputs 0. A full reload of N = 1 then succeeds at address 0.
- With `LOADER_CHECKSUM_EN`:
  - N = 1, bytes 01 02 03, checksum 00 → DONE
  - same stream with checksum 01 → ERROR and `cpu_run` = 0
